// File: rtl/io_request_arbiter_pkg.sv
// rtl/io_request_arbiter_pkg.sv - shared core types for the non-cached I/O request path
package io_request_arbiter_pkg;

  localparam int NUM_CORES        = 4;
  localparam int CORE_ID_WIDTH    = 4;
  localparam int THREADS_PER_CORE = 4;

  typedef logic [CORE_ID_WIDTH-1:0]            core_id_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
  typedef logic [31:0]                         scalar_t;

  typedef struct packed {
    logic              store;
    local_thread_idx_t thread_idx;
    scalar_t           address;
    scalar_t           value;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t          core;
    local_thread_idx_t thread_idx;
    scalar_t           read_value;
  } iorsp_packet_t;

endpackage

// File: rtl/io_bus_interface.sv
// rtl/io_bus_interface.sv - shared peripheral bus; read_data is valid one cycle after read_en
interface io_bus_interface;
  import io_request_arbiter_pkg::*;

  logic    write_en;
  logic    read_en;
  scalar_t address;
  scalar_t write_data;
  scalar_t read_data;

  modport master (output write_en, output read_en, output address, output write_data,
                  input read_data);
  modport slave  (input write_en, input read_en, input address, input write_data,
                  output read_data);
endinterface

// File: rtl/io_request_arbiter_rr.sv
// rtl/io_request_arbiter_rr.sv - round-robin one-hot arbiter; priority starts after the last winner
module rr_arbiter #(
  parameter int NUM_REQUESTS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQUESTS-1:0] request,
  input  logic                    update_lru,
  output logic [NUM_REQUESTS-1:0] grant_oh
);

  generate
    if (NUM_REQUESTS == 1) begin : g_single
      logic unused_ok;
      assign unused_ok = ^{clk, reset, update_lru};
      assign grant_oh  = request;
    end else begin : g_rr
      localparam int IDX_W = $clog2(NUM_REQUESTS);
      localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQUESTS);

      // prio holds the index that currently has highest priority
      logic [IDX_W-1:0] prio;
      logic [IDX_W-1:0] prio_nxt;
      logic [IDX_W-1:0] grant_idx;
      logic [IDX_W:0]   pos;
      logic             found;

      always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = '0;
        for (int i = 0; i < NUM_REQUESTS; i++) begin
          pos = {1'b0, prio} + (IDX_W+1)'(i);
          if (pos >= N_EXT) pos = pos - N_EXT;
          if (!found && request[pos[IDX_W-1:0]]) begin
            grant_oh[pos[IDX_W-1:0]] = 1'b1;
            grant_idx                = pos[IDX_W-1:0];
            found                    = 1'b1;
          end
        end
        prio_nxt = prio;
        if (update_lru && found)
          prio_nxt = (grant_idx == IDX_W'(NUM_REQUESTS - 1)) ? '0 : grant_idx + IDX_W'(1);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) prio <= '0;
        else       prio <= prio_nxt;
      end
    end
  endgenerate

endmodule

// File: rtl/io_request_arbiter.sv
// rtl/io_request_arbiter.sv - arbitrates core I/O requests onto the shared bus
// and broadcasts a response two cycles after each grant.
module io_request_arbiter
  import io_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] ioreq_valid,
  input  ioreq_packet_t             ioreq [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] ioreq_ack,
  output logic                      iorsp_valid,
  output iorsp_packet_t             iorsp,
  io_bus_interface.master           io_bus
);

  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic                      any_grant;
  ioreq_packet_t             granted;
  core_id_t                  granted_core;

  rr_arbiter #(.NUM_REQUESTS(NUM_REQUESTERS)) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   (ioreq_valid),
    .update_lru(|ioreq_valid),
    .grant_oh  (grant_oh)
  );

  assign ioreq_ack = grant_oh;
  assign any_grant = |grant_oh;

  always_comb begin
    granted      = '0;
    granted_core = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_oh[i]) begin
        granted      = ioreq[i];
        granted_core = core_id_t'(i);
      end
    end
  end

  // Issue stage: drives the bus in the cycle after the grant
  logic              wr_en_q, rd_en_q;
  scalar_t           addr_q, wdata_q;
  core_id_t          issue_core_q;
  local_thread_idx_t issue_thread_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      issue_core_q   <= '0;
      issue_thread_q <= '0;
    end else begin
      wr_en_q <= any_grant & granted.store;
      rd_en_q <= any_grant & ~granted.store;
      if (any_grant) begin
        addr_q         <= granted.address;
        wdata_q        <= granted.value;
        issue_core_q   <= granted_core;
        issue_thread_q <= granted.thread_idx;
      end
    end
  end

  assign io_bus.write_en   = wr_en_q;
  assign io_bus.read_en    = rd_en_q;
  assign io_bus.address    = addr_q;
  assign io_bus.write_data = wdata_q;

  // Response stage: the slave's read_data arrives in this cycle, so it is passed straight through
  logic              rsp_valid_q, rsp_load_q;
  core_id_t          rsp_core_q;
  local_thread_idx_t rsp_thread_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_core_q   <= '0;
      rsp_thread_q <= '0;
    end else begin
      rsp_valid_q  <= wr_en_q | rd_en_q;
      rsp_load_q   <= rd_en_q;
      rsp_core_q   <= issue_core_q;
      rsp_thread_q <= issue_thread_q;
    end
  end

  assign iorsp_valid = rsp_valid_q;

  always_comb begin
    iorsp            = '0;
    iorsp.core       = rsp_core_q;
    iorsp.thread_idx = rsp_thread_q;
    iorsp.read_value = rsp_load_q ? io_bus.read_data : '0;
  end

endmodule

// File: tb/tb_io_request_arbiter.sv
// tb/tb_io_request_arbiter.sv - scoreboard bench for io_request_arbiter (4 requesters and 1 requester)
module tb_io_request_arbiter;
  import io_request_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  ioreq_valid = '0;
  ioreq_packet_t ioreq [N];
  logic [N-1:0]  ioreq_ack;
  logic          iorsp_valid;
  iorsp_packet_t iorsp;
  io_bus_interface bus ();

  io_request_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk(clk), .reset(rst), .ioreq_valid(ioreq_valid), .ioreq(ioreq),
    .ioreq_ack(ioreq_ack), .iorsp_valid(iorsp_valid), .iorsp(iorsp), .io_bus(bus));

  logic          v1 = 1'b0;
  ioreq_packet_t ioreq1 [1];
  logic          ack1;
  logic          rsp_valid1;
  iorsp_packet_t rsp1;
  io_bus_interface bus1 ();

  io_request_arbiter #(.NUM_REQUESTERS(1)) dut1 (
    .clk(clk), .reset(rst), .ioreq_valid(v1), .ioreq(ioreq1),
    .ioreq_ack(ack1), .iorsp_valid(rsp_valid1), .iorsp(rsp1), .io_bus(bus1));

  function automatic scalar_t slave_val(input scalar_t a);
    return (a == 32'hFFFF_0004) ? 32'h1234_5678 : (a ^ 32'h5A5A_5A5A) + 32'd17;
  endfunction

  always @(posedge clk) if (bus.read_en)  bus.read_data  <= slave_val(bus.address);
  always @(posedge clk) if (bus1.read_en) bus1.read_data <= slave_val(bus1.address);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {logic store; scalar_t addr; scalar_t data; int cyc;} bus_exp_t;
  typedef struct {core_id_t core; local_thread_idx_t thr; scalar_t rv; int cyc;} rsp_exp_t;
  bus_exp_t bq[$];
  rsp_exp_t rq[$];
  int       grant_log[$];

  // Reference model: pending request per core, round-robin from prio
  bit            pend [N];
  ioreq_packet_t pkt  [N];
  int            prio = 0;

  function automatic ioreq_packet_t rand_pkt();
    ioreq_packet_t p;
    p.store      = 1'($urandom_range(0, 1));
    p.thread_idx = local_thread_idx_t'($urandom_range(0, THREADS_PER_CORE - 1));
    p.address    = 32'hFFFF_0000 | ($urandom & 32'h0000_FFFC);
    p.value      = $urandom;
    return p;
  endfunction

  task automatic step();
    int g;
    logic [N-1:0] e;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      ioreq_valid[i] = pend[i];
      ioreq[i]       = pkt[i];
    end
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int c = (prio + k) % N;
      if (g < 0 && pend[c]) g = c;
    end
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    check("ack", ioreq_ack, e);
    for (int i = 0; i < N; i++) if (ioreq_ack[i]) grant_log.push_back(i);
    if (g >= 0) begin
      bq.push_back('{pkt[g].store, pkt[g].address, pkt[g].value, cyc + 1});
      rq.push_back('{core_id_t'(g), pkt[g].thread_idx,
                     pkt[g].store ? 32'h0 : slave_val(pkt[g].address), cyc + 2});
      pend[g] = 1'b0;
      prio    = (g + 1) % N;
    end
  endtask

  always @(negedge clk) begin : monitor
    bus_exp_t be;
    rsp_exp_t re;
    if (!rst) begin
      check("wr_rd_exclusive", bus.write_en & bus.read_en, 0);
      if (bq.size() > 0 && bq[0].cyc < cyc) begin
        be = bq.pop_front();
        check("bus_missing", 0, 1);
      end
      if (rq.size() > 0 && rq[0].cyc < cyc) begin
        re = rq.pop_front();
        check("rsp_missing", 0, 1);
      end
      if (bus.write_en || bus.read_en) begin
        if (bq.size() == 0) check("bus_unexpected", 1, 0);
        else begin
          be = bq.pop_front();
          check("bus_cycle", cyc, be.cyc);
          check("write_en", bus.write_en, be.store);
          check("read_en", bus.read_en, !be.store);
          check("address", bus.address, be.addr);
          if (be.store) check("write_data", bus.write_data, be.data);
        end
      end
      if (iorsp_valid) begin
        if (rq.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          re = rq.pop_front();
          check("rsp_cycle", cyc, re.cyc);
          check("rsp_core", iorsp.core, re.core);
          check("rsp_thread", iorsp.thread_idx, re.thr);
          check("rsp_read_value", iorsp.read_value, re.rv);
        end
      end
    end
  end

  ioreq_packet_t seq1 [3];

  initial begin
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pkt[i] = '0; ioreq[i] = '0; end
    ioreq1[0] = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_write_en", bus.write_en, 0);
    check("reset_read_en", bus.read_en, 0);
    check("reset_iorsp_valid", iorsp_valid, 0);
    check("reset_address", bus.address, 0);
    check("reset_write_data", bus.write_data, 0);
    check("reset_iorsp", iorsp, 0);
    rst = 1'b0;

    // All cores with continuous demand
    grant_log.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) if (!pend[i]) begin pend[i] = 1'b1; pkt[i] = rand_pkt(); end
      step();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    check("rr_grant_count", grant_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < grant_log.size()) check("rr_grant_order", grant_log[i], i % 4);
    repeat (3) step();

    // Single load from core 2, then a single store from core 0
    pend[2] = 1'b1;
    pkt[2]  = '{store: 1'b0, thread_idx: 2'd1, address: 32'hFFFF_0004, value: 32'h0};
    step();
    repeat (3) step();
    pend[0] = 1'b1;
    pkt[0]  = '{store: 1'b1, thread_idx: 2'd3, address: 32'hFFFF_0010, value: 32'hDEAD_BEEF};
    step();
    repeat (3) step();

    // Core 1 granted last, then cores 1 and 3 together
    pend[1] = 1'b1; pkt[1] = rand_pkt();
    step();
    grant_log.delete();
    pend[1] = 1'b1; pkt[1] = rand_pkt();
    pend[3] = 1'b1; pkt[3] = rand_pkt();
    step();
    step();
    check("after_1_first", grant_log.size() > 0 ? grant_log[0] : -1, 3);
    check("after_1_second", grant_log.size() > 1 ? grant_log[1] : -1, 1);
    repeat (3) step();

    // Reset during the issue cycle of a load
    pend[2] = 1'b1;
    pkt[2]  = '{store: 1'b0, thread_idx: 2'd0, address: 32'hFFFF_0008, value: 32'h0};
    step();
    @(posedge clk); #1;
    ioreq_valid = '0;
    check("pre_reset_read_en", bus.read_en, 1);
    rst = 1'b1;
    #1;
    check("async_read_en", bus.read_en, 0);
    check("async_address", bus.address, 0);
    check("async_iorsp_valid", iorsp_valid, 0);
    bq.delete();
    rq.delete();
    prio = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    pend[0] = 1'b1; pkt[0] = rand_pkt();
    pend[3] = 1'b1; pkt[3] = rand_pkt();
    step();
    step();
    repeat (3) step();

    // Randomized traffic
    repeat (300) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) != 0) begin pend[i] = 1'b1; pkt[i] = rand_pkt(); end
      step();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    while (grant_log.size() > 0) void'(grant_log.pop_front());
    repeat (8) begin
      step();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
    end
    check("bus_queue_drained", bq.size(), 0);
    check("rsp_queue_drained", rq.size(), 0);

    // Single requester: back-to-back load, store, load
    seq1[0] = '{store: 1'b0, thread_idx: 2'd1, address: 32'hFFFF_0020, value: 32'h0};
    seq1[1] = '{store: 1'b1, thread_idx: 2'd2, address: 32'hFFFF_0024, value: 32'hCAFE_F00D};
    seq1[2] = '{store: 1'b0, thread_idx: 2'd3, address: 32'hFFFF_0004, value: 32'h0};
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      v1        = (c < 3);
      ioreq1[0] = (c < 3) ? seq1[c] : '0;
      @(negedge clk);
      check("n1_ack", ack1, v1);
      check("n1_exclusive", bus1.write_en & bus1.read_en, 0);
      if (c >= 1 && c <= 3) begin
        check("n1_write_en", bus1.write_en, seq1[c-1].store);
        check("n1_read_en", bus1.read_en, !seq1[c-1].store);
        check("n1_address", bus1.address, seq1[c-1].address);
      end
      check("n1_rsp_valid", rsp_valid1, (c >= 2 && c <= 4));
      if (c >= 2 && c <= 4) begin
        check("n1_rsp_core", rsp1.core, 0);
        check("n1_rsp_thread", rsp1.thread_idx, seq1[c-2].thread_idx);
        check("n1_rsp_read_value", rsp1.read_value,
              seq1[c-2].store ? 32'h0 : slave_val(seq1[c-2].address));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_request_arbiter.md
IO_REQUEST_ARBITER -- requirements
Module: io_request_arbiter

Interface
REQ-001 Parameter NUM_REQUESTERS, default `NUM_CORES, number of cores sharing the non-cached I/O bus; legal range 1..16 (core_id_t limit).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ioreq_valid  input  [NUM_REQUESTERS]  core i presents a request.
REQ-005 ioreq  input  ioreq_packet_t[NUM_REQUESTERS]  request packet per core: store, thread_idx, address, value.
REQ-006 ioreq_ack  output  [NUM_REQUESTERS]  one-hot grant; the request is accepted in the cycle ack is high.
REQ-007 iorsp_valid  output  1  response broadcast valid.
REQ-008 iorsp  output  iorsp_packet_t  response packet: core, thread_idx, read_value.
REQ-009 io_bus  io_bus_interface.master  --  shared peripheral bus: write_en, read_en, address, write_data out; read_data in, valid one cycle after read_en.

Function
REQ-010 Grant is combinational in cycle N: ioreq_ack[i]=1 for exactly one i with ioreq_valid[i]=1, chosen round-robin; ack is all zeros when no valid.
REQ-011 Round-robin priority starts at the index after the last granted index, wrapping NUM_REQUESTERS-1 -> 0; the pointer is unchanged in cycles without a grant.
REQ-012 With NUM_REQUESTERS==1: ioreq_ack[0]=ioreq_valid[0]; no pointer state.
REQ-013 Issue stage (registered, cycle N+1): write_en = granted.store, read_en = ~granted.store, address = granted.address, write_data = granted.value; write_en/read_en never both high.
REQ-014 Without a grant in cycle N, write_en and read_en are 0 in N+1; address/write_data hold their previous values.
REQ-015 Response stage (registered, cycle N+2): iorsp_valid=1, iorsp.core=granted index (zero-extended to core_id_t), iorsp.thread_idx=granted thread_idx.
REQ-016 iorsp.read_value = io_bus.read_data in N+2 for loads; 0 for stores.
REQ-017 Stores also produce a response at N+2 so the issuing thread can be woken.
REQ-018 Throughput of one request per cycle, back to back, with no bubbles. Total request-to-response latency is 2 cycles.
REQ-019 Requesters hold ioreq_valid/ioreq stable until acked; the block does not buffer unacked requests.
REQ-020 Simultaneous requests from all cores with a continuous demand are each granted once every NUM_REQUESTERS cycles (starvation-free).

Reset
REQ-021 On reset assertion, immediately: write_en=0, read_en=0, iorsp_valid=0, address=0, write_data=0, iorsp=0, RR pointer=0 (core 0 highest priority).
REQ-022 Reset mid-transaction discards in-flight issue and response stages; no response is emitted for them after reset deasserts.
REQ-023 ioreq_ack is combinational and follows ioreq_valid during reset. Requesters do not present requests while reset is high.

Structure
REQ-024 ioreq_packet_t, iorsp_packet_t, core_id_t and scalar_t come from the shared defines package. No new package types are required.
REQ-025 Round-robin selection is a sub-module, rr_arbiter (parameter NUM_REQUESTS; ports clk, reset, request, update_lru, grant_oh), reusable elsewhere in the core.
REQ-026 Pipeline registers (issue, response) are local to io_request_arbiter. No FIFO is used.

Verification
REQ-027 NUM_REQUESTERS=4. Single load: core 2, thread 1, address 0xFFFF0004, slave returns 0x12345678.
  -> ack[2] in N; read_en and address 0xFFFF0004 in N+1; iorsp_valid, core=2, thread 1, read_value 0x12345678 in N+2.
REQ-028 Single store: core 0, address 0xFFFF0010, value 0xDEADBEEF.
  -> write_en and write_data 0xDEADBEEF in N+1; read_en=0; iorsp_valid with read_value 0 in N+2.
REQ-029 All 4 cores request continuously for 8 cycles after reset.
  -> grants in order 0,1,2,3,0,1,2,3; 8 responses on consecutive cycles.
REQ-030 Cores 1 and 3 request after core 1 was last granted.
  -> core 3 granted first, then core 1.
REQ-031 Reset asserted asynchronously in cycle N+1 of a load.
  -> read_en falls immediately; no iorsp_valid after release; next grant goes to core 0 priority.
REQ-032 NUM_REQUESTERS=1 back-to-back load/store/load.
  -> ack follows valid; three responses in consecutive cycles; write_en and read_en never both high.
